regfile_read_stage: RTL and testbench

REGFILE_READ_STAGE -- requirements
Module: regfile_read_stage

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/rd_skid_buffer.sv | 82 ++++++++
 rtl/regfile_read_stage.sv | 94 +++++++++
 tb/tb_regfile_read_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and small helpers for the register-file read stage.
package regfile_pkg;

    localparam int XLEN       = 64;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;
    localparam int FIFO_DEPTH = 2;

    localparam int ADDR_W    = $clog2(NUM_REGS);
    localparam int PAYLOAD_W = 2 * XLEN;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

    // Port 2 data sits in the upper half of the buffered payload.
    typedef struct packed {
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] rd1;
    } rsp_payload_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + 1'b1;
        end
    endfunction

endpackage

// File: rtl/rd_skid_buffer.sv
// Small valid/ready response FIFO holding captured read data until the consumer
// takes it. Output data is forced to zero whenever nothing is valid.
module rd_skid_buffer
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [PAYLOAD_W-1:0] i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [PAYLOAD_W-1:0] o_out_data
);

    logic [PAYLOAD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_count_next;

    // A full buffer refuses new data even when it is popping on the same edge.
    always_comb begin
        w_full      = (r_count == CNT_W'(FIFO_DEPTH));
        o_in_ready  = rst_n & ~w_full;
        o_out_valid = (r_count != {CNT_W{1'b0}});
        w_push      = i_in_valid & o_in_ready;
        w_pop       = o_out_valid & i_out_ready;
    end

    // Occupancy update from the push/pop pair.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_next;
        end
    end

    // Payload storage; entries are written once and never modified in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {PAYLOAD_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    // Head presentation, zeroed while empty.
    always_comb begin
        if (o_out_valid) begin
            o_out_data = r_mem[r_rd_ptr];
        end else begin
            o_out_data = {PAYLOAD_W{1'b0}};
        end
    end

endmodule

// File: rtl/regfile_read_stage.sv
// Two-read/one-write register file with a buffered, valid/ready read response.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data into captured reads.
module regfile_read_stage
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  reg_addr_t       ra1,
    input  reg_addr_t       ra2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            wr_en,
    input  reg_addr_t       wa,
    input  logic [XLEN-1:0] wd
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [XLEN-1:0]      r_regs [NUM_REGS];

    logic                 w_wr_fire;
    logic [XLEN-1:0]      w_rd1_data;
    logic [XLEN-1:0]      w_rd2_data;
    rsp_payload_t         w_capture;
    rsp_payload_t         w_head;
    logic [PAYLOAD_W-1:0] w_head_bits;
    logic                 w_in_ready;

    assign w_wr_fire = wr_en & (wa != ZERO_ADDR);

    // Architectural register storage; the zero register is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (w_wr_fire) begin
            r_regs[wa] <= wd;
        end
    end

    // Read port 1: zero register first, then optional forwarding, then storage.
    always_comb begin
        w_rd1_data = {XLEN{1'b0}};
        if (ra1 == ZERO_ADDR) begin
            w_rd1_data = {XLEN{1'b0}};
        end else if (BYPASS_EN && w_wr_fire && (wa == ra1)) begin
            w_rd1_data = wd;
        end else begin
            w_rd1_data = r_regs[ra1];
        end
    end

    // Read port 2, resolved independently of port 1.
    always_comb begin
        w_rd2_data = {XLEN{1'b0}};
        if (ra2 == ZERO_ADDR) begin
            w_rd2_data = {XLEN{1'b0}};
        end else if (BYPASS_EN && w_wr_fire && (wa == ra2)) begin
            w_rd2_data = wd;
        end else begin
            w_rd2_data = r_regs[ra2];
        end
    end

    // Payload packing for the response buffer.
    always_comb begin
        w_capture     = '{rd2: w_rd2_data, rd1: w_rd1_data};
        w_head        = rsp_payload_t'(w_head_bits);
        req_ready     = w_in_ready;
        rd1           = w_head.rd1;
        rd2           = w_head.rd2;
    end

    rd_skid_buffer u_rsp_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (req_valid),
        .o_in_ready  (w_in_ready),
        .i_in_data   (w_capture),
        .o_out_valid (rsp_valid),
        .i_out_ready (rsp_ready),
        .o_out_data  (w_head_bits)
    );

endmodule

// File: tb/tb_regfile_read_stage.sv
// Scoreboard bench: driver predicts captured data from a register-array model,
// a separate monitor compares every presented response against the queue head.
module tb_regfile_read_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  ra1, ra2, wa;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rd1, rd2, wd;
    logic        wr_en;

    regfile_read_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ra1       (ra1),
        .ra2       (ra2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rd1       (rd1),
        .rd2       (rd2),
        .wr_en     (wr_en),
        .wa        (wa),
        .wd        (wd)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mregs [32];
    int          occ;
    int          errors;
    int          checks;
    bit          done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What a port should return when its request is accepted on this edge.
    function automatic logic [63:0] mread(input logic [4:0] a, input logic we,
                                          input logic [4:0] w_a, input logic [63:0] w_d);
        if (a == 5'd31) return 64'd0;
        if (BYP && we && (w_a == a)) return w_d;
        return mregs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        exp_q.delete();
        occ = 0;
    endtask

    // One clock cycle of stimulus; the prediction is queued once the edge has passed.
    task automatic step(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic rr, input logic we, input logic [4:0] w_a,
                        input logic [63:0] w_d);
        exp_t e;
        bit   acc;
        int   pop;
        @(negedge clk);
        #1;
        chk("req_ready", 64'(req_ready), 64'(occ < 2));
        req_valid = v; ra1 = a1; ra2 = a2; rsp_ready = rr;
        wr_en = we; wa = w_a; wd = w_d;
        acc = v && (occ < 2);
        pop = (occ > 0 && rr) ? 1 : 0;
        e.d1 = mread(a1, we, w_a, w_d);
        e.d2 = mread(a2, we, w_a, w_d);
        occ = occ + (acc ? 1 : 0) - pop;
        if (we && (w_a != 5'd31)) mregs[w_a] = w_d;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(e);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 5'd0, 5'd0, rr, 1'b0, 5'd0, 64'd0);
    endtask

    // Monitor: samples just before the active edge, after the driver has settled inputs.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!done) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    chk("rd1", rd1, exp_q[0].d1);
                    chk("rd2", rd2, exp_q[0].d2);
                    if (rsp_valid && rsp_ready) void'(exp_q.pop_front());
                end else begin
                    chk("rd1_idle", rd1, 64'd0);
                    chk("rd2_idle", rd2, 64'd0);
                end
            end
        end
    end

    initial begin
        logic [4:0] a1, a2, w_a;
        int n;
        errors = 0; checks = 0; done = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
        ra1 = 5'd0; ra2 = 5'd0; wa = 5'd0; wd = 64'd0;
        model_clear();

        #2;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rd1", rd1, 64'd0);
        chk("reset_rd2", rd2, 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("release_req_ready", 64'(req_ready), 64'd1);

        // Write then read, plus same-address reads on both ports.
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 64'h1);
        step(1'b1, 5'd5, 5'd31, 1'b1, 1'b0, 5'd0, 64'd0);
        step(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 64'd0);
        // Same-edge write and read of register 3.
        step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 64'hA);
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 64'd0);
        idle(1'b1); idle(1'b1);

        // Backpressure: three requests while stalled, then drain.
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 64'h2);
        step(1'b1, 5'd7, 5'd5, 1'b0, 1'b0, 5'd0, 64'd0);
        step(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 64'h9);
        step(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 64'd0);
        idle(1'b0); idle(1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // Zero register: plain write, then same-edge write with a read.
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd31, 64'hFFFF);
        step(1'b1, 5'd31, 5'd7, 1'b1, 1'b1, 5'd31, 64'hFFFF);
        idle(1'b1); idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            a1  = 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            w_a = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), a1, a2, ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), w_a, {32'($urandom), 32'($urandom)});
        end

        // Reset with two responses buffered.
        n = 0;
        while (occ > 0 && n < 10) begin idle(1'b1); n++; end
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 64'h1234);
        step(1'b1, 5'd9, 5'd9, 1'b0, 1'b0, 5'd0, 64'd0);
        step(1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        req_valid = 1'b0; wr_en = 1'b0;
        model_clear();
        #1;
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset_req_ready", 64'(req_ready), 64'd0);
        chk("midreset_rd1", rd1, 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 5'd9, 5'd5, 1'b1, 1'b0, 5'd0, 64'd0);
        step(1'b1, 5'd7, 5'd3, 1'b1, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1,
                 1'b0, 5'd0, 64'd0);
        end

        n = 0;
        while (occ > 0 && n < 10) begin idle(1'b1); n++; end
        idle(1'b1);
        @(negedge clk);
        #4;
        done = 1'b1;
        chk("drained_queue", 64'(exp_q.size()), 64'd0);
        chk("drained_occ", 64'(occ), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
